pool2_stage: RTL and testbench



---
 rtl/cnn_pkg.sv | 18 +
 rtl/pool_reduce.sv | 54 +++++
 rtl/pool2_stage.sv | 106 ++++++++++
 tb/tb_pool2_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer stages: FSM states, element type and counter sizing.
package cnn_pkg;

   localparam int WIDTH_BIT = 8;

   typedef logic signed [WIDTH_BIT-1:0] elem_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_reduce.sv
// Combinational POOLxPOOL window reduction: signed maximum, or floor average when POOL_AVG_EN is defined.
module pool_reduce
   import cnn_pkg::*;
#(
   parameter int POOL      = 2,
   parameter int WIDTH_BIT = 8
) (
   input  logic        [POOL-1:0][POOL-1:0][WIDTH_BIT-1:0] window,
   output logic signed [WIDTH_BIT-1:0]                      result
);

`ifdef POOL_AVG_EN
   localparam int SH = 2 * $clog2(POOL);
   localparam int SW = WIDTH_BIT + SH;

   if ((1 << $clog2(POOL)) != POOL) begin : g_pool_pow2
      $error("pool_reduce: average pooling needs POOL to be a power of two");
   end

   // Arithmetic shift floors toward minus infinity; the mean always fits WIDTH_BIT.
   function automatic logic signed [WIDTH_BIT-1:0] avg_floor(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] q;
      q = s >>> SH;
      return q[WIDTH_BIT-1:0];
   endfunction

   logic signed [SW-1:0] sum;

   always_comb begin
      sum = '0;
      for (int a = 0; a < POOL; a++) begin
         for (int b = 0; b < POOL; b++) begin
            sum = sum + SW'($signed(window[a][b]));
         end
      end
      result = avg_floor(sum);
   end
`else
   function automatic logic signed [WIDTH_BIT-1:0] max2(input logic signed [WIDTH_BIT-1:0] x,
                                                        input logic signed [WIDTH_BIT-1:0] y);
      return (x > y) ? x : y;
   endfunction

   always_comb begin
      result = $signed(window[0][0]);
      for (int a = 0; a < POOL; a++) begin
         for (int b = 0; b < POOL; b++) begin
            result = max2(result, $signed(window[a][b]));
         end
      end
   end
`endif

endmodule

// File: rtl/pool2_stage.sv
// Pooling stage: snapshots a feature map on start and emits one pooled element per clock.
// Reduction is signed max by default; define POOL_AVG_EN for floor-average pooling.
module pool2_stage
   import cnn_pkg::*;
#(
   parameter  int IN_SIZE   = 5,
   parameter  int POOL      = 2,
   parameter  int WIDTH_BIT = 8,
   localparam int OUT_SIZE  = IN_SIZE / POOL
) (
   input  logic                                                  clock,
   input  logic                                                  nreset,
   input  logic                                                  start,
   input  logic signed [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0] inpMatrix,
   output logic                                                  busy,
   output logic                                                  done,
   output logic signed [OUT_SIZE-1:0][OUT_SIZE-1:0][WIDTH_BIT-1:0] poolOut
);

   localparam int                CNT_W = cnt_w(OUT_SIZE);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(OUT_SIZE - 1);

   state_t                                      state, state_nxt;
   logic [CNT_W-1:0]                            r, c;
   logic [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0] snap;
   logic [POOL-1:0][POOL-1:0][WIDTH_BIT-1:0]    window;
   logic signed [WIDTH_BIT-1:0]                 red;
   logic                                        last_elem;

   assign last_elem = (r == LAST) && (c == LAST);

   // Trailing rows/columns beyond OUT_SIZE*POOL are never addressed.
   always_comb begin
      window = '0;
      for (int a = 0; a < POOL; a++) begin
         for (int b = 0; b < POOL; b++) begin
            window[a][b] = snap[POOL * int'(r) + a][POOL * int'(c) + b];
         end
      end
   end

   pool_reduce #(
      .POOL      (POOL),
      .WIDTH_BIT (WIDTH_BIT)
   ) u_reduce (
      .window (window),
      .result (red)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (last_elem) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         r       <= '0;
         c       <= '0;
         snap    <= '0;
         poolOut <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snap <= inpMatrix;
                  r    <= '0;
                  c    <= '0;
                  busy <= 1'b1;
               end
            end
            SCAN: begin
               poolOut[r][c] <= red;
               if (c == LAST) begin
                  c <= '0;
                  if (r == LAST) begin
                     r    <= '0;
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     r <= r + 1'b1;
                  end
               end else begin
                  c <= c + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pool2_stage.sv
// Scoreboard bench for pool2_stage: stimulus pushes expected pooled maps, a monitor checks them on done.
module tb_pool2_stage;

   localparam int IN_SIZE = 5;
   localparam int POOL    = 2;
   localparam int WB      = 8;
   localparam int OS      = IN_SIZE / POOL;

   typedef logic [IN_SIZE-1:0][IN_SIZE-1:0][WB-1:0] mat_t;

   typedef struct packed {
      logic [3:0][31:0] v;
      logic [31:0]      cyc;
   } exp_t;

   logic clock = 1'b0;
   logic nreset = 1'b0;
   logic start = 1'b0;
   mat_t inpMatrix = '0;
   logic busy, done;
   logic [OS-1:0][OS-1:0][WB-1:0] poolOut;

   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   exp_t sb[$];

   pool2_stage #(
      .IN_SIZE   (IN_SIZE),
      .POOL      (POOL),
      .WIDTH_BIT (WB)
   ) dut (
      .clock     (clock),
      .nreset    (nreset),
      .start     (start),
      .inpMatrix (inpMatrix),
      .busy      (busy),
      .done      (done),
      .poolOut   (poolOut)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Called at a negedge: the following posedge captures the frame.
   task automatic issue(input mat_t m, input int e00, input int e01, input int e10, input int e11);
      exp_t e;
      e.v[0] = e00; e.v[1] = e01; e.v[2] = e10; e.v[3] = e11;
      e.cyc  = cyc + 5;
      start     = 1'b1;
      inpMatrix = m;
      sb.push_back(e);
   endtask

   task automatic release_start();
      @(negedge clock);
      start     = 1'b0;
      inpMatrix = {IN_SIZE*IN_SIZE{8'h5A}};
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clock);
         n++;
      end
      check({name, "_done_seen"}, int'(done), 1);
   endtask

   always @(negedge clock) begin
      if (nreset && done) begin
         check("done_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, int'(e.cyc));
            check("busy_at_done", int'(busy), 0);
            for (int i = 0; i < OS; i++) begin
               for (int j = 0; j < OS; j++) begin
                  check($sformatf("poolOut[%0d][%0d]", i, j),
                        int'($signed(poolOut[i][j])), int'($signed(e.v[i*OS+j])));
               end
            end
         end
      end
   end

   mat_t ramp, negm, winm, sevens;

   initial begin
      for (int i = 0; i < IN_SIZE; i++) begin
         for (int j = 0; j < IN_SIZE; j++) begin
            ramp[i][j]   = WB'(5*i + j);
            negm[i][j]   = (i == 4 || j == 4) ? 8'sd50 : -8'sd3;
            winm[i][j]   = 8'sd127;
            sevens[i][j] = 8'sd7;
         end
      end
      negm[1][1] = -8'sd1;
      winm[0][0] = -8'sd1;
      winm[0][1] = -8'sd2;
      winm[1][0] = -8'sd3;
      winm[1][1] = 8'sd1;

      repeat (2) @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pool", int'(poolOut), 0);
      nreset = 1'b1;
      @(negedge clock);

      // Reset two scan edges into a frame.
      issue(ramp, 0, 0, 0, 0);
      release_start();
      repeat (2) @(negedge clock);
      nreset = 1'b0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_pool", int'(poolOut), 0);
      sb.delete();
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);

`ifdef POOL_AVG_EN
      issue(ramp, 3, 5, 13, 15);
`else
      issue(ramp, 6, 8, 16, 18);
`endif
      release_start();
      wait_done("ramp");
      @(negedge clock);
      check("done_one_cycle", int'(done), 0);
      repeat (2) @(negedge clock);

`ifdef POOL_AVG_EN
      issue(negm, -3, -3, -3, -3);
`else
      issue(negm, -1, -3, -3, -3);
`endif
      release_start();
      wait_done("neg");
      repeat (2) @(negedge clock);

      // Back-to-back: second start lands in the done cycle of the first.
`ifdef POOL_AVG_EN
      issue(winm, -2, 127, 127, 127);
`else
      issue(winm, 1, 127, 127, 127);
`endif
      release_start();
      wait_done("b2b_first");
      issue(sevens, 7, 7, 7, 7);
      release_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done("b2b_second");
      repeat (8) @(negedge clock);
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
